regalu_pipe: RTL
================

# regalu_pipe

Parametrised, pipelined successor to the register-file/ALU pair. Holds `NREGS` registers of `WIDTH` bits with one-hot read/write selects. Register 0 is hardwired to zero. Operands are read combinationally onto `abus`/`bbus`. The ALU result is registered into an execute stage, driven on `dbus`, and written back on the next clock. Adds an issue handshake, status flags, and optional write-back bypass; sits between instruction decode and the datapath result bus.

## Interface
- `WIDTH`, default 32, datapath width in bits (≥ 2)
- `NREGS`, default 32, number of registers and width of each select bus (≥ 2)
- `clk` — in — 1 — sole clock, rising-edge
- `reset_n` — in — 1 — asynchronous, active-low reset
- `in_valid` — in — 1 — operation issued this cycle
- `Aselect` — in — NREGS — one-hot source-A register select
- `Bselect` — in — NREGS — one-hot source-B register select
- `Dselect` — in — NREGS — one-hot destination select
- `S` — in — 3 — ALU op
- `Cin` — in — 1 — carry-in for ADD and SUB
- `abus` — out — WIDTH — source-A operand (combinational)
- `bbus` — out — WIDTH — source-B operand (combinational)
- `dbus` — out — WIDTH — execute-stage result (registered)
- `dvalid` — out — 1 — execute stage holds a valid result
- `cout` — out — 1 — carry-out of the registered result
- `ovf` — out — 1 — signed overflow of the registered result
- `zero` — out — 1 — registered result equals 0

## Operation
- **Op encoding:**
  - 000 XOR
  - 001 XNOR
  - 010 ADD, A+B+Cin
  - 011 SUB, A+~B+Cin; Cin=1 gives a true difference
  - 100 OR
  - 101 NOR
  - 110 AND
  - 111 MOVA, result = A
- **Arithmetic:** computed at WIDTH+1 bits.
  - `cout` = bit WIDTH.
  - `ovf` = sign(A)==sign(B') && sign(result)!=sign(A), where B' = B (ADD) or ~B (SUB).
  - For logic ops and MOVA, `cout` and `ovf` are 0.
- **Reads:**
  - `abus` = bitwise OR of all registers whose select bit is set.
  - An all-zero select yields 0.
  - Register 0 always reads 0.
- **Execute stage:**
  - On each rising `clk`, the stage captures `in_valid`, the ALU result, the flags, and `Dselect`.
  - `dvalid` follows the captured `in_valid`.
  - `dbus` and the flags hold their last value when `dvalid`=0.
- **Write-back:**
  - On the rising edge after capture, if the stage is valid, every register with its captured `Dselect` bit set (excluding bit 0) loads `dbus`.
  - An all-zero `Dselect` means no write.
  - Multi-hot `Dselect` writes all selected registers.
- **Reset:**
  - All registers are 0.
  - `dvalid`, `dbus`, `cout`, `ovf` and `zero` are 0.
  - A pending write-back is discarded. Reset is effective immediately, without waiting for a clock edge.

## Timing
- Cycle N: `in_valid`=1; `abus`/`bbus` reflect the selects within the same cycle.
- Edge N+1: `dbus`, flags and `dvalid`=1 are visible.
- Edge N+2: the register holds the result; a read in cycle N+2 returns it.
- Back-to-back hazard: an op in cycle N+1 reading the destination of the op from cycle N.
  - Without bypass, it sees the pre-write value.
  - Behaviour with bypass is given under Configuration.
- Simultaneous write-back and read of the same register in the same cycle returns the old value; the new value appears in the next cycle.
- Issue rate: one op per cycle, no stalls.

## Configuration
- `REGALU_BYPASS_EN` defined:
  - If `dvalid`=1 and the captured `Dselect` bit i (i≠0) is set, read paths substitute `dbus` for register i.
  - A dependent op issued in the following cycle therefore sees the new value.
- Not defined: no forwarding; software must leave one idle cycle before reading a result.

## Structure
- Package `regalu_pkg`: op encoding constants (`OP_XOR` … `OP_MOVA`) and the 3-bit op typedef.
- Sub-module `regalu_alu`: combinational ALU, parametrised by `WIDTH`, producing result, `cout` and `ovf`.
- Top level: register array, read OR-trees, execute register, write-back and bypass mux.

## Test plan
Defaults WIDTH=32, NREGS=32.
- **Reset:** assert `reset_n`=0 mid-run → all reads 0; `dbus`=0, `dvalid`=0, flags 0. A write pending at reset never lands.
- **XNOR into R1:** XNOR R0,R0 with `Dselect`=0x2 → `dbus`=FFFFFFFF at N+1; reading R1 at N+2 gives `abus`=FFFFFFFF.
- **ADD carry chain:** ADD FFFFFFFF+00000001, Cin=0 → `dbus`=0, `cout`=1, `zero`=1, `ovf`=0.
- **SUB overflow:** SUB 7FFFFFFF−FFFFFFFF, Cin=1 → `dbus`=80000000, `ovf`=1. SUB FFFFFFFF−FFFFFFFF, Cin=0 → FFFFFFFF.
- **Dependent read:** write R2=5, then in the next cycle read R2 → `abus`=5 with `REGALU_BYPASS_EN`, 0 without.
- **R0 and no-write cases:**
  - Write to R0 (`Dselect`=0x1) → R0 still reads 0.
  - Dselect=0 → no register changes.
  - MOVA of R3 → `dbus`=R3.

Source files
------------

// File: rtl/regalu_pkg.sv
// Shared definitions for the regalu_pipe register-file/ALU slice:
// the 3-bit ALU op type and its encodings.
package regalu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_XOR  = 3'b000;
    localparam op_t OP_XNOR = 3'b001;
    localparam op_t OP_ADD  = 3'b010;
    localparam op_t OP_SUB  = 3'b011;
    localparam op_t OP_OR   = 3'b100;
    localparam op_t OP_NOR  = 3'b101;
    localparam op_t OP_AND  = 3'b110;
    localparam op_t OP_MOVA = 3'b111;

endpackage

// File: rtl/regalu_alu.sv
// Combinational ALU for regalu_pipe: logic ops, MOVA, and ADD/SUB with
// carry-in computed at WIDTH+1 bits to expose carry-out and signed overflow.
import regalu_pkg::*;

module regalu_alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    logic signed [WIDTH-1:0] b_op;
    logic        [WIDTH:0]   sum;

    // Overflow when both addends share a sign that the sum does not keep.
    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] x,
                                        input logic signed [WIDTH-1:0] y,
                                        input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    always_comb begin
        b_op = (op_t'(s) == OP_SUB) ? ~b : b;
        sum  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        case (op_t'(s))
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_ADD, OP_SUB: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
                ovf    = signed_ovf(a, b_op, sum[WIDTH-1:0]);
            end
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_AND:  result = a & b;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/regalu_pipe.sv
// Register file with one-hot selects, combinational operand reads, a registered
// execute stage and write-back one clock later. Define REGALU_BYPASS_EN to forward dbus.
import regalu_pkg::*;

module regalu_pipe #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [NREGS-1:0] Aselect,
    input  logic [NREGS-1:0] Bselect,
    input  logic [NREGS-1:0] Dselect,
    input  logic [2:0]       S,
    input  logic             Cin,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] bbus,
    output logic [WIDTH-1:0] dbus,
    output logic             dvalid,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [NREGS-1:0][WIDTH-1:0] rd_val;

    op_t              op_p0;
    logic [WIDTH-1:0] res_p0;
    logic             cout_p0;
    logic             ovf_p0;

    logic             vld_p1;
    logic [WIDTH-1:0] res_p1;
    logic             cout_p1;
    logic             ovf_p1;
    logic             zero_p1;
    logic [NREGS-1:0] dsel_p1;

    assign op_p0 = op_t'(S);

    // Stage p0: per-register read value (R0 forced to zero), then OR-trees.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rd_val[i] = (i == 0) ? '0 : regs[i];
`ifdef REGALU_BYPASS_EN
            if (i != 0 && vld_p1 && dsel_p1[i]) begin
                rd_val[i] = res_p1;
            end
`endif
        end
    end

    always_comb begin
        abus = '0;
        bbus = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (Aselect[i]) abus = abus | rd_val[i];
            if (Bselect[i]) bbus = bbus | rd_val[i];
        end
    end

    regalu_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (abus),
        .b      (bbus),
        .s      (op_p0),
        .cin    (Cin),
        .result (res_p0),
        .cout   (cout_p0),
        .ovf    (ovf_p0)
    );

    // Stage p1: execute register; data and flags hold while no op is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            cout_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            zero_p1 <= 1'b0;
            dsel_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                res_p1  <= res_p0;
                cout_p1 <= cout_p0;
                ovf_p1  <= ovf_p0;
                zero_p1 <= (res_p0 == '0);
                dsel_p1 <= Dselect;
            end
        end
    end

    // Stage p2: write-back of the execute result into every selected register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (vld_p1) begin
            for (int i = 0; i < NREGS; i++) begin
                if (i != 0 && dsel_p1[i]) begin
                    regs[i] <= res_p1;
                end
            end
        end
    end

    assign dbus   = res_p1;
    assign dvalid = vld_p1;
    assign cout   = cout_p1;
    assign ovf    = ovf_p1;
    assign zero   = zero_p1;

endmodule
